// File: rtl/mem_tester.sv
// mem_tester: parametrised memory test master on a req/ack memory bus.
// Writes a selectable data pattern over an address window, reads it back,
// and reports mismatch count and first failing address.
// Optional bus-hang timeout: define MEM_TESTER_TIMEOUT_EN.
module mem_tester #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       NUM_WORDS = 256,
  parameter int unsigned       STRIDE    = 4,
  parameter int unsigned       TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              timeout,
  output logic [2:0]        state
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  if (DATA_W < 8) begin : g_chk_data_w
    $error("mem_tester: DATA_W must be at least 8");
  end
  if (NUM_WORDS < 1 || TIMEOUT < 1) begin : g_chk_counts
    $error("mem_tester: NUM_WORDS and TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE_WR = 3'd1,
    WR     = 3'd2,
    PRE_RD = 3'd3,
    RD     = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             cur_state, nxt_state;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [1:0]         mode_q, mode_n;
  logic [ADDR_W-1:0]  addr_n, fea_n;
  logic [DATA_W-1:0]  wdata_n;
  logic               rd_n, wr_n, busy_n, done_n, to_q, to_n;
  logic [15:0]        err_n;
  logic               last;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [IDX_W-1:0] i);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] p;
    a = BASE_ADDR + ADDR_W'(STRIDE) * ADDR_W'(i);
    p = '0;
    case (m)
      2'd0: p = DATA_W'(a);
      2'd1: p = ~DATA_W'(a);
      2'd2: p = DATA_W'(1) << (32'(i) % DATA_W);
      default: begin
        for (int unsigned b = 0; b < DATA_W; b++) p[b] = (b % 2 == 1) ^ i[0];
      end
    endcase
    return p;
  endfunction

  assign last  = (idx == IDX_W'(NUM_WORDS - 1));
  assign state = cur_state;

`ifdef MEM_TESTER_TIMEOUT_EN
  localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TCNT_W-1:0] tcnt, tcnt_n;
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  // Next-state and next-output computation; every register has a next value here.
  always_comb begin
    nxt_state = cur_state;
    idx_n     = idx;
    mode_n    = mode_q;
    addr_n    = mem_addr;
    wdata_n   = mem_write_data;
    rd_n      = mem_read;
    wr_n      = mem_write;
    busy_n    = busy;
    done_n    = done;
    err_n     = err_count;
    fea_n     = first_err_addr;
    to_n      = to_q;
`ifdef MEM_TESTER_TIMEOUT_EN
    tcnt_n    = tcnt;
`endif
    case (cur_state)
      IDLE, DONE: begin
        if (start) begin
          nxt_state = PRE_WR;
          idx_n     = '0;
          addr_n    = BASE_ADDR;
          err_n     = '0;
          fea_n     = '0;
          to_n      = 1'b0;
          done_n    = 1'b0;
          busy_n    = 1'b1;
          mode_n    = mode;
        end
      end
      PRE_WR: begin
        wdata_n   = pattern(mode_q, idx);
        wr_n      = 1'b1;
        nxt_state = WR;
`ifdef MEM_TESTER_TIMEOUT_EN
        tcnt_n    = '0;
`endif
      end
      PRE_RD: begin
        rd_n      = 1'b1;
        nxt_state = RD;
`ifdef MEM_TESTER_TIMEOUT_EN
        tcnt_n    = '0;
`endif
      end
      WR, RD: begin
        if (mem_ack) begin
          wr_n = 1'b0;
          rd_n = 1'b0;
          if (cur_state == RD && mem_read_data != pattern(mode_q, idx)) begin
            if (err_count == '0) fea_n = mem_addr;
            if (err_count != 16'hFFFF) err_n = err_count + 16'd1;
          end
          if (last) begin
            idx_n  = '0;
            addr_n = BASE_ADDR;
            if (cur_state == WR) begin
              nxt_state = PRE_RD;
            end else begin
              nxt_state = DONE;
              done_n    = 1'b1;
              busy_n    = 1'b0;
            end
          end else begin
            idx_n     = idx + IDX_W'(1);
            addr_n    = mem_addr + ADDR_W'(STRIDE);
            nxt_state = (cur_state == WR) ? PRE_WR : PRE_RD;
          end
        end
`ifdef MEM_TESTER_TIMEOUT_EN
        else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
          wr_n      = 1'b0;
          rd_n      = 1'b0;
          to_n      = 1'b1;
          done_n    = 1'b1;
          busy_n    = 1'b0;
          nxt_state = DONE;
        end else begin
          tcnt_n = tcnt + TCNT_W'(1);
        end
`endif
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state      <= IDLE;
      idx            <= '0;
      mode_q         <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      to_q           <= 1'b0;
    end else begin
      cur_state      <= nxt_state;
      idx            <= idx_n;
      mode_q         <= mode_n;
      mem_addr       <= addr_n;
      mem_write_data <= wdata_n;
      mem_read       <= rd_n;
      mem_write      <= wr_n;
      busy           <= busy_n;
      done           <= done_n;
      err_count      <= err_n;
      first_err_addr <= fea_n;
      to_q           <= to_n;
    end
  end

`ifdef MEM_TESTER_TIMEOUT_EN
  // Strobe-cycle counter for the bus-hang abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tcnt <= '0;
    else       tcnt <= tcnt_n;
  end
`endif

endmodule
